// File: rtl/lsb_mem_port.sv
// In-order load/store queue feeding a req/gnt/rvalid data-memory port and reporting completions to the ROB.
// Optional define LSB_MISALIGN_TRAP_EN adds result_trap and traps misaligned halfword/word accesses.
module lsb_mem_port #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [4:0]       op,
    input  logic [ROB_W-1:0] rob_number,
    input  logic [31:0]      ls_value,
    input  logic             flush,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob,
    output logic             buf_full,
    output logic             overflow,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             result_valid,
    output logic [ROB_W-1:0] result_rob,
    output logic [31:0]      result_value
`ifdef LSB_MISALIGN_TRAP_EN
   ,output logic             result_trap
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t state;

    logic [31:0]      e_addr [DEPTH];
    logic [4:0]       e_op   [DEPTH];
    logic [ROB_W-1:0] e_rob  [DEPTH];
    logic [31:0]      e_val  [DEPTH];
    logic [DEPTH-1:0] e_vld;
    logic [DEPTH-1:0] e_cm;

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             in_ok, push, pop;
    logic [31:0]      h_addr, h_val;
    logic [4:0]       h_op;
    logic [ROB_W-1:0] h_rob;
    logic             h_vld, h_cm, h_store;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      ld_ext;
    logic [31:0]      ld_data;
    logic [31:0]      rd_shift;
    logic [15:0]      rd_half;

`ifdef LSB_MISALIGN_TRAP_EN
    logic             h_mis;
    logic             trap_pend;
`endif

    function automatic logic op_is_valid(input logic [4:0] o);
        case (o)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    // A full FIFO still accepts a push when the head retires on the same edge.
    always_comb begin
        in_ok = op_is_valid(op);
        pop   = (state == S_RESP) && !flush;
        push  = in_ok && !flush && ((count < CNT_W'(DEPTH)) || pop);
    end

    assign buf_full = (count == CNT_W'(DEPTH));

    always_comb begin
        h_addr  = e_addr[head];
        h_val   = e_val[head];
        h_op    = e_op[head];
        h_rob   = e_rob[head];
        h_vld   = e_vld[head];
        h_cm    = e_cm[head];
        h_store = h_op[3];
    end

    always_comb begin
        st_wdata = h_val;
        st_wstrb = 4'b1111;
        case (h_op)
            5'd8: begin
                st_wdata = {4{h_val[7:0]}};
                st_wstrb = 4'b0001 << h_addr[1:0];
            end
            5'd9: begin
                st_wdata = {2{h_val[15:0]}};
                st_wstrb = h_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = h_val;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {h_addr[1:0], 3'b000};
        rd_half  = h_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (h_op)
            5'd0:    ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            5'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
            5'd3:    ld_ext = {24'd0, rd_shift[7:0]};
            5'd4:    ld_ext = {16'd0, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

`ifdef LSB_MISALIGN_TRAP_EN
    always_comb begin
        case (h_op)
            5'd1, 5'd4, 5'd9: h_mis = h_addr[0];
            5'd2, 5'd10:      h_mis = (h_addr[1:0] != 2'b00);
            default:          h_mis = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= addr;
            e_op[tail]   <= op;
            e_rob[tail]  <= rob_number;
            e_val[tail]  <= ls_value;
        end
    end

    // Pop clears the head slot first so a same-edge push into that slot wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            e_vld    <= '0;
            e_cm     <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_ok && !flush && !push)
                overflow <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                e_vld <= '0;
                e_cm  <= '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (commit_valid && e_vld[i] && e_op[i][3] && (e_rob[i] == commit_rob))
                        e_cm[i] <= 1'b1;
                end
                if (pop) begin
                    e_vld[head] <= 1'b0;
                    e_cm[head]  <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (push) begin
                    e_vld[tail] <= 1'b1;
                    e_cm[tail]  <= op[3] && commit_valid && (rob_number == commit_rob);
                    tail        <= tail + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            ld_data      <= '0;
            result_valid <= 1'b0;
            result_rob   <= '0;
            result_value <= '0;
`ifdef LSB_MISALIGN_TRAP_EN
            result_trap  <= 1'b0;
            trap_pend    <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
`ifdef LSB_MISALIGN_TRAP_EN
            result_trap  <= 1'b0;
`endif
            if (flush) begin
                mem_req <= 1'b0;
`ifdef LSB_MISALIGN_TRAP_EN
                trap_pend <= 1'b0;
`endif
                // A load already granted still owes one rvalid that must be swallowed.
                case (state)
                    S_REQ:   state <= (mem_gnt && !mem_we) ? S_DRAIN : S_IDLE;
                    S_WAIT:  state <= mem_rvalid ? S_IDLE : S_DRAIN;
                    S_DRAIN: state <= mem_rvalid ? S_IDLE : S_DRAIN;
                    default: state <= S_IDLE;
                endcase
            end else begin
                case (state)
                    S_IDLE: begin
`ifdef LSB_MISALIGN_TRAP_EN
                        if (h_vld && h_mis) begin
                            trap_pend <= 1'b1;
                            state     <= S_RESP;
                        end else
`endif
                        if (h_vld && (!h_store || h_cm)) begin
                            mem_req   <= 1'b1;
                            mem_we    <= h_store;
                            mem_addr  <= {h_addr[31:2], 2'b00};
                            mem_wdata <= h_store ? st_wdata : '0;
                            mem_wstrb <= h_store ? st_wstrb : '0;
                            state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            if (mem_we) begin
                                ld_data <= '0;
                                state   <= S_RESP;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (mem_rvalid) begin
                            ld_data <= ld_ext;
                            state   <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        result_valid <= 1'b1;
                        result_rob   <= h_rob;
`ifdef LSB_MISALIGN_TRAP_EN
                        result_value <= trap_pend ? h_addr : ld_data;
                        result_trap  <= trap_pend;
                        trap_pend    <= 1'b0;
`else
                        result_value <= ld_data;
`endif
                        state <= S_IDLE;
                    end
                    S_DRAIN: begin
                        if (mem_rvalid)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Scoreboard bench for lsb_mem_port: directed ops, memory responder checks requests, monitor checks results.
module tb_lsb_mem_port;

    localparam int DEPTH = 4;
    localparam int ROB_W = 3;

    logic             clk;
    logic             rst;
    logic [31:0]      addr;
    logic [4:0]       op;
    logic [ROB_W-1:0] rob_number;
    logic [31:0]      ls_value;
    logic             flush;
    logic             commit_valid;
    logic [ROB_W-1:0] commit_rob;
    logic             buf_full;
    logic             overflow;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             result_valid;
    logic [ROB_W-1:0] result_rob;
    logic [31:0]      result_value;

    lsb_mem_port #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .op(op), .rob_number(rob_number),
        .ls_value(ls_value), .flush(flush), .commit_valid(commit_valid),
        .commit_rob(commit_rob), .buf_full(buf_full), .overflow(overflow),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .result_valid(result_valid), .result_rob(result_rob),
        .result_value(result_value)
    );

    typedef struct {
        logic [ROB_W-1:0] rob;
        logic [31:0]      value;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_t;

    res_t exp_res[$];
    mem_t exp_mem[$];
    int   vecs = 0;
    int   errs = 0;
    int   rv_lat = 1;
    bit   mem_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic exp_ld(input logic [31:0] a, input logic [31:0] rd,
                          input logic [ROB_W-1:0] r, input logic [31:0] v);
        exp_mem.push_back('{addr: a, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0, rdata: rd});
        exp_res.push_back('{rob: r, value: v});
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] wd, input logic [ROB_W-1:0] r);
        exp_mem.push_back('{addr: a, we: 1'b1, wstrb: s, wdata: wd, rdata: 32'h0});
        exp_res.push_back('{rob: r, value: 32'h0});
    endtask

    task automatic push_op(input logic [4:0] o, input logic [31:0] a,
                           input logic [ROB_W-1:0] r, input logic [31:0] v);
        op         = o;
        addr       = a;
        rob_number = r;
        ls_value   = v;
        @(negedge clk);
        op = 5'h1F;
    endtask

    task automatic commit(input logic [ROB_W-1:0] r);
        commit_valid = 1'b1;
        commit_rob   = r;
        @(negedge clk);
        commit_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_res.size() != 0 || exp_mem.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_res.size() + exp_mem.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_buf_full"}, 32'(buf_full), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_result_rob"}, 32'(result_rob), 0);
        chk({tag, "_result_value"}, result_value, 0);
    endtask

    // Memory responder: grants every request, returns rdata rv_lat cycles after a load grant.
    initial begin : mem_model
        mem_t        m;
        int          pend;
        logic [31:0] pend_data;
        pend       = 0;
        pend_data  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end
            mem_gnt = 1'b0;
            if (rst && mem_req && mem_en) begin
                mem_gnt = 1'b1;
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_req), 0);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
                    chk("mem_wdata", mem_wdata, m.wdata);
                    if (!mem_we) begin
                        pend      = rv_lat;
                        pend_data = m.rdata;
                    end
                end
            end
        end
    end

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst && result_valid) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_result_valid", 32'(result_valid), 0);
                end else begin
                    e = exp_res.pop_front();
                    chk("result_rob", 32'(result_rob), 32'(e.rob));
                    chk("result_value", result_value, e.value);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int seen;
        bit saw;
        rst          = 1'b0;
        op           = 5'h1F;
        addr         = 32'h0;
        rob_number   = '0;
        ls_value     = 32'h0;
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_rob   = '0;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b1;
        @(negedge clk);

        // LW with latency check: result_valid first seen 4 cycles after the push edge.
        exp_ld(32'h100, 32'hDEADBEEF, 3'd1, 32'hDEADBEEF);
        push_op(5'd2, 32'h100, 3'd1, 32'h0);
        chk("lw_req_not_yet", 32'(mem_req), 0);
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("lw_req_after_1", 32'(mem_req), 1);
            if (result_valid && seen == 0) seen = k;
        end
        chk("lw_latency", seen, 4);
        wait_done("lw_done");

        // Back-to-back sub-word loads exercising lane select and extension.
        exp_ld(32'h100, 32'h80FF0000, 3'd2, 32'hFFFFFF80);
        exp_ld(32'h100, 32'h80FF0000, 3'd3, 32'h00000080);
        exp_ld(32'h100, 32'h80FF0000, 3'd4, 32'hFFFF80FF);
        exp_ld(32'h100, 32'h80FF0000, 3'd5, 32'h000080FF);
        push_op(5'd0, 32'h103, 3'd2, 32'h0);
        push_op(5'd3, 32'h103, 3'd3, 32'h0);
        push_op(5'd1, 32'h102, 3'd4, 32'h0);
        push_op(5'd4, 32'h102, 3'd5, 32'h0);
        wait_done("subword_done");
        exp_ld(32'h100, 32'h12347FFF, 3'd6, 32'h00007FFF);
        push_op(5'd1, 32'h100, 3'd6, 32'h0);
        wait_done("lh_low_done");

        // SH waits for its own commit; a commit to another tag does not release it.
        exp_st(32'h200, 4'b1100, 32'h12341234, 3'd5);
        push_op(5'd9, 32'h202, 3'd5, 32'h00001234);
        saw = 1'b0;
        commit(3'd4);
        repeat (6) begin
            @(negedge clk);
            if (mem_req) saw = 1'b1;
        end
        chk("sh_waits_commit", 32'(saw), 0);
        commit(3'd5);
        wait_done("sh_done");

        // SB committed on the same edge it is pushed.
        exp_st(32'h200, 4'b0010, 32'hABABABAB, 3'd6);
        op = 5'd8; addr = 32'h201; rob_number = 3'd6; ls_value = 32'h000000AB;
        commit_valid = 1'b1; commit_rob = 3'd6;
        @(negedge clk);
        op = 5'h1F; commit_valid = 1'b0;
        wait_done("sb_done");

        // Load behind an uncommitted store stays queued.
        exp_st(32'h300, 4'b1111, 32'hCAFEF00D, 3'd7);
        exp_ld(32'h304, 32'h11112222, 3'd0, 32'h11112222);
        push_op(5'd10, 32'h300, 3'd7, 32'hCAFEF00D);
        push_op(5'd2, 32'h304, 3'd0, 32'h0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req) saw = 1'b1;
        end
        chk("ld_behind_store_waits", 32'(saw), 0);
        commit(3'd7);
        wait_done("order_done");

        // Overflow: DEPTH+1 ops behind an uncommitted head store.
        exp_st(32'h400, 4'b1111, 32'h5555AAAA, 3'd0);
        exp_ld(32'h404, 32'h00000001, 3'd1, 32'h00000001);
        exp_ld(32'h408, 32'h00000002, 3'd2, 32'h00000002);
        exp_ld(32'h40C, 32'h00000003, 3'd3, 32'h00000003);
        push_op(5'd10, 32'h400, 3'd0, 32'h5555AAAA);
        push_op(5'd2, 32'h404, 3'd1, 32'h0);
        push_op(5'd2, 32'h408, 3'd2, 32'h0);
        push_op(5'd2, 32'h40C, 3'd3, 32'h0);
        chk("buf_full_at_depth", 32'(buf_full), 1);
        chk("overflow_before_drop", 32'(overflow), 0);
        push_op(5'd2, 32'h410, 3'd4, 32'h0);
        chk("buf_full_after_drop", 32'(buf_full), 1);
        chk("overflow_sticky_set", 32'(overflow), 1);
        commit(3'd0);
        wait_done("overflow_drain_done");
        chk("buf_full_cleared", 32'(buf_full), 0);
        chk("overflow_still_set", 32'(overflow), 1);

        // Flush while a load is in WAIT: its late rvalid is drained, no result.
        rv_lat = 5;
        exp_mem.push_back('{addr: 32'h500, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0, rdata: 32'h77777777});
        push_op(5'd2, 32'h500, 3'd2, 32'h0);
        push_op(5'd2, 32'h504, 3'd3, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_mem_queue", exp_mem.size(), 0);
        chk("flush_overflow_kept", 32'(overflow), 1);
        rv_lat = 1;
        exp_ld(32'h600, 32'h000000C3, 3'd4, 32'h000000C3);
        push_op(5'd3, 32'h600, 3'd4, 32'h0);
        wait_done("post_flush_done");

        // Asynchronous reset in the middle of a held request.
        mem_en = 1'b0;
        push_op(5'd2, 32'h700, 3'd1, 32'h0);
        @(negedge clk);
        chk("req_held", 32'(mem_req), 1);
        #2 rst = 1'b0;
        #1 check_reset_outs("midreq_reset");
        @(negedge clk);
        rst = 1'b1;
        mem_en = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req) saw = 1'b1;
        end
        chk("no_req_after_reset", 32'(saw), 0);

        chk("scoreboard_empty", exp_res.size() + exp_mem.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/lsb_mem_port.md
Name: lsb_mem_port

Overview:
- Consumer end of the address-unit → load/store path.
- Accepts resolved memory ops (addr, op, rob_number, ls_value) one per cycle and queues them in order in a FIFO.
- Issues each op to the data-memory port under a req/gnt/rvalid handshake; stores wait for ROB commit.
- Returns load data or store completion to the ROB, tagged with rob_number.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- ROB_W, 3, ROB tag width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  effective address from AU.
- op  in  5  op code; 5'h1F = bubble.
- rob_number  in  ROB_W  ROB tag of op.
- ls_value  in  32  store data (don't-care for loads).
- flush  in  1  mispredict flush.
- commit_valid  in  1  ROB commit strobe.
- commit_rob  in  ROB_W  tag being committed.
- buf_full  out  1  FIFO count == DEPTH.
- overflow  out  1  sticky: an op was dropped because FIFO full.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-shifted store data.
- mem_wstrb  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- result_valid  out  1  one-cycle completion pulse.
- result_rob  out  ROB_W  completing tag.
- result_value  out  32  extended load data; 0 for stores.

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE. buf_full=0, overflow=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, result_valid=0, result_rob=0, result_value=0.
- Op codes: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 8 SB, 9 SH, 10 SW. Any other value, including 1F, is ignored. Upstream presents each op for exactly one cycle.
- Push:
  - On posedge with a valid op: entry written if count<DEPTH, or if count==DEPTH and a pop occurs the same cycle.
  - Otherwise the op is dropped and overflow sets.
  - Pointers wrap mod DEPTH.
- Store commit: each entry holds a committed bit. commit_valid with commit_rob matching any valid store entry sets that bit. Commit in the same cycle as the store's push also sets it.
- FSM:
  - IDLE: head present AND (head is load OR head committed) → REQ. mem_req rises the next cycle.
  - REQ: mem_req=1; addr/we/wdata/wstrb held stable. On mem_gnt: load → WAIT, store → RESP.
  - WAIT: mem_req=0. On mem_rvalid, capture rdata, lane-select by addr[1:0], sign- or zero-extend → RESP.
  - RESP: result_valid=1 for one cycle with head tag; pop head → IDLE.
  - DRAIN: wait for the mem_rvalid of an abandoned load, discard it → IDLE.
- Ordering: strictly in order. A load behind an uncommitted store waits.
- Latency: load pushed at edge N into empty FIFO, mem_gnt same cycle as mem_req → mem_req visible after N+1, result_valid visible after edge N+3+L, where L = gnt-to-rvalid cycles (rvalid the cycle after gnt is L=1).
- Store lanes: SB strobe = 1<<addr[1:0], data replicated byte. SH strobe = 0011 or 1100 by addr[1], data replicated halfword. SW strobe = 1111.
- Misalignment without the optional feature: low address bits are used as given; an aligned access is still issued.
- Flush (highest priority):
  - FIFO cleared; committed bits cleared; same-cycle push dropped.
  - In REQ with a coincident mem_gnt on a load, or in WAIT → DRAIN.
  - In REQ otherwise, or in RESP → IDLE; no result pulse on the following cycle.
  - overflow is not cleared by flush.

Optional Feature:
- Macro LSB_MISALIGN_TRAP_EN.
- Defined:
  - Halfword op with addr[0]=1, or word op with addr[1:0]≠0, issues no memory request; goes directly to RESP.
  - Output result_trap (1 bit) is asserted with result_valid, and result_value = faulting addr.
  - A misaligned store traps at the head without waiting for commit.
- Undefined: no result_trap port; misaligned access behaves as described in Behaviour.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, L=1 → mem_addr=0x100, wstrb=0; result_valid one cycle, result_value=0xDEADBEEF, result_rob matches.
- LB addr=0x103, rdata=0x80FF0000 → result 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH addr=0x202, ls_value=0x1234, rob=5: no mem_req until commit_valid/commit_rob=5. Then wstrb=1100, wdata=0x12341234, result_value=0.
- Push DEPTH+1 ops while head store uncommitted → buf_full=1, overflow=1, last op never completes. After commit, the DEPTH queued ops complete in order.
- Flush while in WAIT, then rvalid arrives → DRAIN absorbs it, no result_valid, FIFO empty, next pushed load issues normally.
- Assert rst mid-REQ → mem_req low immediately, all outputs at reset values.
